// File: rtl/mem_access_unit.sv
// Load/store unit between a byte-addressed CPU port and a word-addressed RAM
// with one-cycle read latency. Sub-word stores are read-modify-write; bad
// requests are answered with an error and never reach the RAM.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  output logic                  ram_write_enable,
  input  logic [31:0]           ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [1:0]              offset_q;
  logic [15:0]             wdata_q;
  logic [ADDR_WIDTH-1:0]   ram_address_q;
  logic [31:0]             ram_data_in_q;
  logic                    resp_valid_q;
  logic                    resp_error_q;
  logic [31:0]             resp_rdata_q;

  logic                    accept;
  logic                    req_err;
  logic [7:0]              byte_lane;
  logic [15:0]             half_lane;
  logic [31:0]             load_data;
  logic [31:0]             merged_word;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Classify the incoming request: illegal funct3 or misaligned address.
  always_comb begin
    req_err = 1'b0;
    if (req_write) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else if (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_err = 1'b1;
  end

  // Next-state logic; sw skips the read because it overwrites the whole word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_RESP;
          end else if (req_write && req_funct3 == 3'd2) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = write_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pick the addressed lane of the read word and extend it for the load type.
  always_comb begin
    byte_lane = 8'd0;
    case (offset_q)
      2'd0: byte_lane = ram_data_out[7:0];
      2'd1: byte_lane = ram_data_out[15:8];
      2'd2: byte_lane = ram_data_out[23:16];
      2'd3: byte_lane = ram_data_out[31:24];
      default: byte_lane = 8'd0;
    endcase
    half_lane = offset_q[1] ? ram_data_out[31:16] : ram_data_out[15:0];
    load_data = 32'd0;
    case (funct3_q)
      3'd0: load_data = {{24{byte_lane[7]}}, byte_lane};
      3'd1: load_data = {{16{half_lane[15]}}, half_lane};
      3'd2: load_data = ram_data_out;
      3'd4: load_data = {24'd0, byte_lane};
      3'd5: load_data = {16'd0, half_lane};
      default: load_data = 32'd0;
    endcase
  end

  // Byte-lane merge for sb/sh: replace only the targeted lane(s) of the read word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int LO  = 8 * gi;
      localparam int WLO = 8 * (gi % 2);
      logic sel;
      assign sel = funct3_q[0] ? (offset_q[1] == 1'(gi / 2))
                               : (offset_q == 2'(gi));
      assign merged_word[LO+7:LO] = sel ? (funct3_q[0] ? wdata_q[WLO+7:WLO] : wdata_q[7:0])
                                        : ram_data_out[LO+7:LO];
    end
  endgenerate

  // State, latched request, RAM-side registers and the response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      funct3_q      <= 3'd0;
      offset_q      <= 2'd0;
      wdata_q       <= 16'd0;
      ram_address_q <= '0;
      ram_data_in_q <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q       <= req_write;
        funct3_q      <= req_funct3;
        offset_q      <= req_addr[1:0];
        wdata_q       <= req_wdata[15:0];
        ram_address_q <= req_addr >> 2;
        ram_data_in_q <= req_wdata;
      end
      if (state_q == S_DATA && write_q) begin
        ram_data_in_q <= merged_word;
      end
      resp_valid_q <= (state_d == S_RESP);
      resp_error_q <= (state_q == S_IDLE) && accept && req_err;
      resp_rdata_q <= (state_q == S_DATA && !write_q) ? load_data : 32'd0;
    end
  end

  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_write_enable = (state_q == S_WRITE) && !reset;
  assign resp_valid       = resp_valid_q;
  assign resp_error       = resp_error_q;
  assign resp_rdata       = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a small synchronous RAM, a transaction-level
// reference model checked every cycle, and directed requests with literal
// expected results.
module tb_mem_access_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_in;
  logic          ram_write_enable;
  logic [31:0]   ram_data_out;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  int checks = 0;
  int errors = 0;
  logic init_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Word RAM with one-cycle read latency.
  logic [31:0] ram_mem [16];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= (i == 1) ? 32'h8899AABB : 32'd0;
    end else if (ram_write_enable) begin
      ram_mem[ram_address[3:0]] <= ram_data_in;
    end
    ram_data_out <= ram_mem[ram_address[3:0]];
  end

  // Reference model: each accepted request takes a fixed number of edges to
  // reach its response (error 1, sw 2, load 3, sb/sh 4); stores commit to the
  // reference memory on the edge that enters the response.
  logic [31:0] ref_mem [16];
  int          m_cnt = 0;
  bit          m_resp = 0;
  bit          m_store = 0;
  bit          m_err = 0;
  logic [31:0] m_rdata = 0;
  logic [31:0] m_new_word = 0;
  logic [3:0]  m_idx = 0;
  logic [31:0] m_addr = 0;
  int          accept_cnt = 0;

  always @(posedge clk) begin
    logic [31:0] word, rd, nw, bytev, halfv;
    bit e;
    int lat, sh, hs;
    if (init_mem) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = (i == 1) ? 32'h8899AABB : 32'd0;
    end
    if (reset) begin
      m_cnt = 0; m_resp = 0; m_store = 0; m_addr = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_resp = 1;
        if (m_store) ref_mem[m_idx] = m_new_word;
      end
    end else if (req_valid) begin
      accept_cnt++;
      e = req_write ? (req_funct3 > 2) : (req_funct3 == 3 || req_funct3 >= 6);
      if (req_funct3 == 1 || req_funct3 == 5) e = e || req_addr[0];
      if (req_funct3 == 2) e = e || (req_addr[1:0] != 0);
      m_idx  = req_addr[5:2];
      m_addr = req_addr / 4;
      word   = ref_mem[m_idx];
      sh     = 8 * int'(req_addr[1:0]);
      hs     = 16 * int'(req_addr[1]);
      bytev  = (word >> sh) & 32'hFF;
      halfv  = (word >> hs) & 32'hFFFF;
      rd = 0;
      case (req_funct3)
        0: rd = (bytev >= 128) ? (bytev | 32'hFFFFFF00) : bytev;
        1: rd = (halfv >= 32768) ? (halfv | 32'hFFFF0000) : halfv;
        2: rd = word;
        4: rd = bytev;
        5: rd = halfv;
        default: rd = 0;
      endcase
      nw = req_wdata;
      if (req_funct3 == 0) nw = (word & ~(32'hFF << sh)) | ((req_wdata & 32'hFF) << sh);
      if (req_funct3 == 1) nw = (word & ~(32'hFFFF << hs)) | ((req_wdata & 32'hFFFF) << hs);
      lat = e ? 1 : (req_write ? ((req_funct3 == 2) ? 2 : 4) : 3);
      m_err      = e;
      m_store    = req_write && !e;
      m_rdata    = (req_write || e) ? 32'd0 : rd;
      m_new_word = nw;
      m_cnt      = lat - 1;
      if (m_cnt == 0) m_resp = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int          resp_count = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;
  always @(posedge clk) begin
    bit exp_we;
    #2;
    exp_we = m_store && (m_cnt == 1) && !reset;
    chk("req_ready", 32'(req_ready), 32'(!m_resp && m_cnt == 0 && !reset));
    chk("resp_valid", 32'(resp_valid), 32'(m_resp));
    chk("ram_write_enable", 32'(ram_write_enable), 32'(exp_we));
    if (m_resp) begin
      chk("resp_error", 32'(resp_error), 32'(m_err));
      chk("resp_rdata", resp_rdata, m_rdata);
    end
    if (exp_we) begin
      chk("ram_address", ram_address, m_addr);
      chk("ram_data_in", ram_data_in, m_new_word);
    end
    if (resp_valid) begin
      resp_count++;
      last_rdata = resp_rdata;
      last_err   = resp_error;
    end
  end

  task automatic wait_resp(input int n0, input string name);
    for (int i = 0; i < 20 && resp_count == n0; i++) @(negedge clk);
    checks++;
    if (resp_count == n0) begin
      errors++;
      $display("FAIL %s_timeout actual=no_response required=response", name);
    end
  endtask

  // One request from IDLE; returns at a negedge with the unit idle again.
  task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n0;
    n0 = resp_count;
    req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(n0, name);
    chk({name, "_rdata"}, last_rdata, exp_rdata);
    chk({name, "_err"}, 32'(last_err), 32'(exp_err));
    $display("txn %s w=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d",
             name, w, f3, addr, wdata, last_rdata, last_err);
    @(negedge clk);
  endtask

  initial begin
    int n0, ac;
    reset = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_data_in", ram_data_in, 32'd0);
    chk("rst_ram_we", 32'(ram_write_enable), 32'd0);
    reset = 1'b0;

    do_req("sw_0c",   1'b1, 3'd2, 32'h0C, 32'h00000007, 32'h00000000, 1'b0);
    do_req("lw_0c",   1'b0, 3'd2, 32'h0C, 32'h0,        32'h00000007, 1'b0);
    do_req("lb_05",   1'b0, 3'd0, 32'h05, 32'h0,        32'hFFFFFFAA, 1'b0);
    do_req("lbu_05",  1'b0, 3'd4, 32'h05, 32'h0,        32'h000000AA, 1'b0);
    do_req("lh_06",   1'b0, 3'd1, 32'h06, 32'h0,        32'hFFFF8899, 1'b0);
    do_req("lhu_04",  1'b0, 3'd5, 32'h04, 32'h0,        32'h0000AABB, 1'b0);
    do_req("lw_04",   1'b0, 3'd2, 32'h04, 32'h0,        32'h8899AABB, 1'b0);
    do_req("sb_07",   1'b1, 3'd0, 32'h07, 32'h12345611, 32'h00000000, 1'b0);
    do_req("lw_sb",   1'b0, 3'd2, 32'h04, 32'h0,        32'h1199AABB, 1'b0);
    do_req("sh_04",   1'b1, 3'd1, 32'h04, 32'h0000CAFE, 32'h00000000, 1'b0);
    do_req("lw_sh",   1'b0, 3'd2, 32'h04, 32'h0,        32'h1199CAFE, 1'b0);
    do_req("err_lw",  1'b0, 3'd2, 32'h0E, 32'h0,        32'h00000000, 1'b1);
    do_req("err_sh",  1'b1, 3'd1, 32'h05, 32'hFFFF,     32'h00000000, 1'b1);
    do_req("err_f3",  1'b0, 3'd3, 32'h04, 32'h0,        32'h00000000, 1'b1);
    do_req("err_st4", 1'b1, 3'd4, 32'h04, 32'h0,        32'h00000000, 1'b1);
    do_req("lw_after_err", 1'b0, 3'd2, 32'h04, 32'h0,   32'h1199CAFE, 1'b0);

    // Back-to-back: req_valid stays high across two requests.
    n0 = resp_count;
    req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h04; req_valid = 1'b1;
    wait_resp(n0, "busy1");
    chk("busy1_rdata", last_rdata, 32'h1199CAFE);
    $display("txn busy1 lw addr=00000004 rdata=%h", last_rdata);
    @(negedge clk);
    req_funct3 = 3'd4; req_addr = 32'h05;
    ac = accept_cnt;
    n0 = resp_count;
    for (int i = 0; i < 10 && accept_cnt == ac; i++) @(negedge clk);
    req_valid = 1'b0;
    wait_resp(n0, "busy2");
    chk("busy2_rdata", last_rdata, 32'h000000CA);
    $display("txn busy2 lbu addr=00000005 rdata=%h", last_rdata);
    @(negedge clk);

    // Reset while an sb is in its write cycle.
    req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h04; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !ram_write_enable; i++) @(negedge clk);
    chk("rstw_reached_write", 32'(ram_write_enable), 32'd1);
    reset = 1'b1;
    n0 = resp_count;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rstw_ready_after", 32'(req_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("rstw_no_resp", 32'(resp_count), 32'(n0));
    chk("rstw_mem_word1", ram_mem[1], 32'h1199CAFE);
    $display("txn sb_reset addr=00000004 word1=%h", ram_mem[1]);

    chk("mem_word3", ram_mem[3], 32'h00000007);
    for (int i = 0; i < 4; i++) chk("mem_vs_model", ram_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
